rf_writeback_queue: RTL and testbench

//  Write-side driver for the 16x32 register file. Buffers write-back results from the
//  EX/MEM stages in a small FIFO and drains them one per cycle onto the C/PW/RFLd port.
//  A result targeting R15 also pulses PCWR, so the register file's R15 mux selects PW over PCin.

---
 rtl/rf_writeback_queue.sv | 141 ++++++++++++++
 tb/tb_rf_writeback_queue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rf_writeback_queue.sv
// Write-back FIFO feeding the register file write port (C/PW/RFLd/PCWR).
// Optional decode bypass lookup is built when RF_WB_BYPASS_EN is defined.
module rf_writeback_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 4
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     REQ_VALID,
    output logic                     REQ_READY,
    input  logic [AW-1:0]            REQ_RD,
    input  logic [DW-1:0]            REQ_DATA,
    input  logic                     HOLD,
    output logic [AW-1:0]            C,
    output logic [DW-1:0]            PW,
    output logic                     RFLd,
    output logic                     PCWR,
    output logic [$clog2(DEPTH):0]   COUNT,
    input  logic [AW-1:0]            SA,
    input  logic [AW-1:0]            SB,
    input  logic [AW-1:0]            SD,
    output logic [DW-1:0]            FA,
    output logic [DW-1:0]            FB,
    output logic [DW-1:0]            FD,
    output logic                     HA,
    output logic                     HB,
    output logic                     HD
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CW    = PTR_W + 1;

    logic [AW-1:0]    r_rd_mem   [DEPTH];
    logic [DW-1:0]    r_data_mem [DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CW-1:0]    r_count;
    logic [AW-1:0]    r_c;
    logic [DW-1:0]    r_pw;
    logic             r_rfld;
    logic             r_pcwr;

    logic w_ready;
    logic w_push;
    logic w_pop;

    // Readiness looks only at occupancy, so a pop on a full queue never admits a push.
    assign w_ready = (r_count != CW'(DEPTH));
    assign w_push  = REQ_VALID & w_ready;
    assign w_pop   = ~HOLD & (r_count != '0);

    always_ff @(posedge CLK) begin
        if (w_push && !RST) begin
            r_rd_mem[r_wptr]   <= REQ_RD;
            r_data_mem[r_wptr] <= REQ_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_c     <= '0;
            r_pw    <= '0;
            r_rfld  <= 1'b0;
            r_pcwr  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
                r_c    <= r_rd_mem[r_rptr];
                r_pw   <= r_data_mem[r_rptr];
                r_rfld <= 1'b1;
                r_pcwr <= (r_rd_mem[r_rptr] == '1);
            end else begin
                r_rfld <= 1'b0;
                r_pcwr <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign REQ_READY = w_ready;
    assign C         = r_c;
    assign PW        = r_pw;
    assign RFLd      = r_rfld;
    assign PCWR      = r_pcwr;
    assign COUNT     = r_count;

`ifdef RF_WB_BYPASS_EN
    logic [AW-1:0] w_sel [3];
    logic          w_hit [3];
    logic [DW-1:0] w_fwd [3];

    assign w_sel[0] = SA;
    assign w_sel[1] = SB;
    assign w_sel[2] = SD;

    // Scan output stage first, then entries oldest to newest so the youngest match wins.
    always_comb begin
        for (int unsigned p = 0; p < 3; p++) begin
            w_hit[p] = r_rfld && (r_c == w_sel[p]);
            w_fwd[p] = w_hit[p] ? r_pw : '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                logic [PTR_W-1:0] idx;
                idx = r_rptr + PTR_W'(i);
                if ((CW'(i) < r_count) && (r_rd_mem[idx] == w_sel[p])) begin
                    w_hit[p] = 1'b1;
                    w_fwd[p] = r_data_mem[idx];
                end
            end
        end
    end

    assign HA = w_hit[0];
    assign HB = w_hit[1];
    assign HD = w_hit[2];
    assign FA = w_fwd[0];
    assign FB = w_fwd[1];
    assign FD = w_fwd[2];
`else
    logic w_unused_sel;
    assign w_unused_sel = ^{SA, SB, SD};

    assign HA = 1'b0;
    assign HB = 1'b0;
    assign HD = 1'b0;
    assign FA = '0;
    assign FB = '0;
    assign FD = '0;
`endif

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Randomized and directed checks of rf_writeback_queue against a queue-based model.
// Bypass expectations follow RF_WB_BYPASS_EN as compiled.
module tb_rf_writeback_queue;

    logic        CLK;
    logic        RST;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [3:0]  REQ_RD;
    logic [31:0] REQ_DATA;
    logic        HOLD;
    logic [3:0]  C;
    logic [31:0] PW;
    logic        RFLd;
    logic        PCWR;
    logic [2:0]  COUNT;
    logic [3:0]  SA, SB, SD;
    logic [31:0] FA, FB, FD;
    logic        HA, HB, HD;

    rf_writeback_queue #(.DEPTH(4), .DW(32), .AW(4)) dut (
        .CLK(CLK), .RST(RST), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_RD(REQ_RD), .REQ_DATA(REQ_DATA), .HOLD(HOLD),
        .C(C), .PW(PW), .RFLd(RFLd), .PCWR(PCWR), .COUNT(COUNT),
        .SA(SA), .SB(SB), .SD(SD), .FA(FA), .FB(FB), .FD(FD),
        .HA(HA), .HB(HB), .HD(HD)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pending writes as a plain queue plus the visible write port.
    typedef struct packed {
        logic [3:0]  rd;
        logic [31:0] d;
    } ent_t;

    ent_t        q[$];
    logic        m_rfld, m_pcwr;
    logic [3:0]  m_c;
    logic [31:0] m_pw;
    bit          m_started = 0;

    always @(posedge CLK) begin
        bit can_take;
        m_started = 1;
        if (RST) begin
            q.delete();
            m_rfld = 0; m_pcwr = 0; m_c = 0; m_pw = 0;
        end else begin
            can_take = (q.size() != 4);
            if (!HOLD && q.size() > 0) begin
                m_rfld = 1;
                m_c    = q[0].rd;
                m_pw   = q[0].d;
                m_pcwr = (q[0].rd == 4'd15);
                void'(q.pop_front());
            end else begin
                m_rfld = 0;
                m_pcwr = 0;
            end
            if (REQ_VALID && can_take) q.push_back('{rd: REQ_RD, d: REQ_DATA});
        end
    end

    function automatic logic [32:0] model_byp(input logic [3:0] s);
`ifdef RF_WB_BYPASS_EN
        for (int i = q.size() - 1; i >= 0; i--)
            if (q[i].rd == s) return {1'b1, q[i].d};
        if (m_rfld && m_c == s) return {1'b1, m_pw};
`endif
        return '0;
    endfunction

    always @(negedge CLK) begin
        if (m_started) begin
            chk("count", 64'(COUNT), 64'(q.size()));
            chk("ready", 64'(REQ_READY), 64'(q.size() != 4));
            chk("rfld",  64'(RFLd), 64'(m_rfld));
            chk("pcwr",  64'(PCWR), 64'(m_pcwr));
            chk("c",     64'(C),    64'(m_c));
            chk("pw",    64'(PW),   64'(m_pw));
            chk("byp_a", 64'({HA, FA}), 64'(model_byp(SA)));
            chk("byp_b", 64'({HB, FB}), 64'(model_byp(SB)));
            chk("byp_d", 64'({HD, FD}), 64'(model_byp(SD)));
        end
    end

    // Inputs change 2 time units after an edge; the next edge consumes them.
    task automatic drive(input logic rst, input logic v, input logic [3:0] rd,
                         input logic [31:0] d, input logic h);
        RST = rst; REQ_VALID = v; REQ_RD = rd; REQ_DATA = d; HOLD = h;
        @(posedge CLK);
        #2;
    endtask

    task automatic idle(input logic h);
        drive(1'b0, 1'b0, 4'd0, 32'd0, h);
    endtask

    initial begin
        RST = 1; REQ_VALID = 0; REQ_RD = 0; REQ_DATA = 0; HOLD = 0;
        SA = 0; SB = 0; SD = 0;
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);

        // reset discards queued entries
        for (int i = 0; i < 3; i++) drive(0, 1, 4'(i + 1), 32'(i + 50), 1);
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        @(negedge CLK);
        chk("t1_count", 64'(COUNT), 64'd0);
        chk("t1_rfld", 64'(RFLd), 64'd0);
        chk("t1_c", 64'(C), 64'd0);
        chk("t1_pw", 64'(PW), 64'd0);
        chk("t1_ready", 64'(REQ_READY), 64'd1);

        // single write, one-cycle drain latency
        drive(0, 1, 4'd3, 32'd90, 0);
        @(negedge CLK);
        chk("t2_rfld_n", 64'(RFLd), 64'd0);
        idle(0);
        @(negedge CLK);
        chk("t2_rfld", 64'(RFLd), 64'd1);
        chk("t2_c", 64'(C), 64'd3);
        chk("t2_pw", 64'(PW), 64'd90);
        idle(0);
        @(negedge CLK);
        chk("t2_rfld_off", 64'(RFLd), 64'd0);

        // fill under HOLD, fifth push dropped, then ordered drain
        for (int i = 0; i < 5; i++) drive(0, 1, 4'(i + 1), 32'(100 + i), 1);
        @(negedge CLK);
        chk("t3_count", 64'(COUNT), 64'd4);
        chk("t3_ready", 64'(REQ_READY), 64'd0);
        chk("t3_rfld", 64'(RFLd), 64'd0);
        for (int i = 0; i < 4; i++) begin
            idle(0);
            @(negedge CLK);
            chk("t3_drain_c", 64'(C), 64'(i + 1));
            chk("t3_drain_pw", 64'(PW), 64'(100 + i));
            chk("t3_drain_rfld", 64'(RFLd), 64'd1);
        end
        idle(0);
        @(negedge CLK);
        chk("t3_empty_rfld", 64'(RFLd), 64'd0);

        // R15 strobe
        drive(0, 1, 4'd15, 32'd35, 0);
        idle(0);
        @(negedge CLK);
        chk("t4_pcwr", 64'(PCWR), 64'd1);
        chk("t4_rfld", 64'(RFLd), 64'd1);
        chk("t4_pw", 64'(PW), 64'd35);
        drive(0, 1, 4'd10, 32'd7, 0);
        idle(0);
        @(negedge CLK);
        chk("t4_pcwr10", 64'(PCWR), 64'd0);
        chk("t4_c10", 64'(C), 64'd10);

        // simultaneous push/pop across pointer wrap
        drive(0, 1, 4'd1, 32'd200, 1);
        drive(0, 1, 4'd2, 32'd201, 1);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 4'(i + 3), 32'(202 + i), 0);
            @(negedge CLK);
            chk("t5_count", 64'(COUNT), 64'd2);
            chk("t5_c", 64'(C), 64'(i + 1));
        end
        for (int i = 0; i < 3; i++) idle(0);

        // bypass lookup with two pending writes to R10
        drive(0, 1, 4'd10, 32'd9, 1);
        drive(0, 1, 4'd10, 32'd16, 1);
        SA = 4'd10; SB = 4'd4; SD = 4'd10;
        REQ_VALID = 0;
        @(negedge CLK);
`ifdef RF_WB_BYPASS_EN
        chk("t6_ha", 64'(HA), 64'd1);
        chk("t6_fa", 64'(FA), 64'd16);
`else
        chk("t6_ha", 64'(HA), 64'd0);
        chk("t6_fa", 64'(FA), 64'd0);
`endif
        chk("t6_hb", 64'(HB), 64'd0);
        idle(0);
        idle(0);
        idle(0);

        // randomized traffic with occasional reset
        for (int n = 0; n < 3000; n++) begin
            SA = 4'($urandom_range(0, 15));
            SB = 4'($urandom_range(0, 15));
            SD = 4'($urandom_range(0, 15));
            drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 99) < 60),
                  4'($urandom_range(0, 15)), $urandom, ($urandom_range(0, 99) < 35));
        end
        idle(0);
        @(negedge CLK);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
